id_exe_stage_reg: RTL
=====================

// Module: id_exe_stage_reg
// PURPOSE
//  Pipeline register between the decode (ID) and execute (EXE) stages of the 5-stage core.
//  Captures the decoder's control bundle (mem_read, mem_write, wb_en, br, exe_cmd), the PC,
//  operand values and the destination register every cycle. Supports three actions:
//   - hold on a global freeze
//   - bubble on a branch flush or load-use hazard
//   - normal load
//  Keeps a saturating count of inserted bubbles for CPI analysis.
// PARAMETERS
//  DATA_W   32  width of PC and operand/store values
//  REG_W     5  register index width (dest/src fields)
//  CMD_W     4  execute-command width from the decoder
//  CNT_W    16  width of the bubble counter
// PORTS
//  clk           in   1       rising-edge clock
//  rst           in   1       synchronous, active-high reset
//  freeze        in   1       global stall (memory not ready); hold all state
//  flush         in   1       branch taken in EXE; insert bubble
//  hazard        in   1       load-use hazard detected in ID; insert bubble
//  pc_in         in   DATA_W  PC+4 of the ID instruction
//  mem_read_in   in   1       decoder control
//  mem_write_in  in   1       decoder control
//  wb_en_in      in   1       decoder control
//  br_in         in   2       00 none, 01 BEZ, 10 BNE, 11 JMP
//  exe_cmd_in    in   CMD_W   ALU command
//  val1_in       in   DATA_W  rs1 value
//  val2_in       in   DATA_W  rs2 value or sign-extended immediate (muxed in ID)
//  st_val_in     in   DATA_W  store data
//  dest_in       in   REG_W   destination register
//  src1_in       in   REG_W   source 1 index (used only with FORWARDING_EN)
//  src2_in       in   REG_W   source 2 index (used only with FORWARDING_EN)
//  *_out         out  same    registered copy of each *_in above
//  valid_out     out  1       1 = real instruction in EXE, 0 = bubble/reset
//  bubble_cnt    out  CNT_W   number of bubbles inserted since reset
// BEHAVIOUR
//  - Latency: 1 cycle. Every output is a flop; no combinational in-to-out path.
//  - Per-edge priority: rst > freeze > (flush | hazard) > load.
//  - rst: all outputs are 0, including valid_out and bubble_cnt.
//  - freeze=1: every output, including bubble_cnt, holds its value, even if flush/hazard are also 1.
//  - flush|hazard (freeze=0): bubble.
//     - mem_read, mem_write, wb_en, br, exe_cmd and valid_out become 0.
//     - pc, val1, val2, st_val, dest and src become 0.
//     - bubble_cnt += 1, saturating at all-ones (2^CNT_W-1); it does not wrap.
//     - flush and hazard together count as one bubble.
//  - load (all controls 0): each *_out takes its *_in; valid_out becomes 1.
//  - The bubble must never write back or access memory: wb_en, mem_read and mem_write
//    are guaranteed 0 while valid_out = 0.
//  - Reset mid-stream: the first edge after rst deasserts loads normally. No state
//    survives reset.
//  - bubble_cnt is purely diagnostic; no other output depends on it.
// CONFIGURATION
//  FORWARDING_EN defined:
//   - src1_out/src2_out are registered under the same hold/bubble/load rules and feed
//     the forwarding unit.
//  FORWARDING_EN undefined:
//   - src1_out/src2_out are tied to 0.
//   - src1_in/src2_in are ignored; their flops are not synthesized.
// TESTING
//  1. rst=1 for 2 cycles with all inputs 1 -> every output 0, bubble_cnt=0.
//  2. Load ADD: wb_en=1, exe_cmd=4'b0000, val1=5, val2=7, dest=3, pc=0x10 ->
//     next cycle outputs match, valid_out=1.
//  3. freeze=1 for 3 cycles while inputs change to val1=9 -> outputs hold val1=5,
//     valid_out=1; the cycle after freeze drops, val1_out=9.
//  4. Load LD (mem_read=1, wb_en=1), then hazard=1 -> valid_out=0, mem_read_out=0,
//     wb_en_out=0, bubble_cnt=1.
//  5. flush=1 and hazard=1 together, then flush=1 with freeze=1 ->
//     first edge bubble_cnt=2; second edge holds at 2.
//  6. Preload bubble_cnt to 0xFFFF via 65535 bubbles, then one more flush ->
//     bubble_cnt stays 0xFFFF.
//  Under FORWARDING_EN: load src1=4, src2=6 -> next cycle src1_out=4, src2_out=6;
//  without it -> both 0.

Source files
------------

// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID/EXE pipeline register with freeze hold, flush/hazard bubble and saturating bubble counter.
// Define FORWARDING_EN to register src1/src2 for the forwarding unit; otherwise they read as 0.
module id_exe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CMD_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              hazard,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              wb_en_in,
  input  logic [1:0]        br_in,
  input  logic [CMD_W-1:0]  exe_cmd_in,
  input  logic [DATA_W-1:0] val1_in,
  input  logic [DATA_W-1:0] val2_in,
  input  logic [DATA_W-1:0] st_val_in,
  input  logic [REG_W-1:0]  dest_in,
  input  logic [REG_W-1:0]  src1_in,
  input  logic [REG_W-1:0]  src2_in,
  output logic [DATA_W-1:0] pc_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              wb_en_out,
  output logic [1:0]        br_out,
  output logic [CMD_W-1:0]  exe_cmd_out,
  output logic [DATA_W-1:0] val1_out,
  output logic [DATA_W-1:0] val2_out,
  output logic [DATA_W-1:0] st_val_out,
  output logic [REG_W-1:0]  dest_out,
  output logic [REG_W-1:0]  src1_out,
  output logic [REG_W-1:0]  src2_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  bubble_cnt
);
  logic bub;
  logic [DATA_W-1:0] pc_d, pc_q, val1_d, val1_q, val2_d, val2_q, st_val_d, st_val_q;
  logic mem_read_d, mem_read_q, mem_write_d, mem_write_q, wb_en_d, wb_en_q, valid_d, valid_q;
  logic [1:0] br_d, br_q;
  logic [CMD_W-1:0] exe_cmd_d, exe_cmd_q;
  logic [REG_W-1:0] dest_d, dest_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  always_comb begin
    bub = flush | hazard;
    pc_d = freeze ? pc_q : bub ? '0 : pc_in;
    mem_read_d = freeze ? mem_read_q : bub ? 1'b0 : mem_read_in;
    mem_write_d = freeze ? mem_write_q : bub ? 1'b0 : mem_write_in;
    wb_en_d = freeze ? wb_en_q : bub ? 1'b0 : wb_en_in;
    br_d = freeze ? br_q : bub ? 2'b00 : br_in;
    exe_cmd_d = freeze ? exe_cmd_q : bub ? '0 : exe_cmd_in;
    val1_d = freeze ? val1_q : bub ? '0 : val1_in;
    val2_d = freeze ? val2_q : bub ? '0 : val2_in;
    st_val_d = freeze ? st_val_q : bub ? '0 : st_val_in;
    dest_d = freeze ? dest_q : bub ? '0 : dest_in;
    valid_d = freeze ? valid_q : !bub;
    cnt_d = (freeze || !bub) ? cnt_q : cnt_q + CNT_W'(cnt_q != '1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      wb_en_q <= 1'b0;
      br_q <= '0;
      exe_cmd_q <= '0;
      val1_q <= '0;
      val2_q <= '0;
      st_val_q <= '0;
      dest_q <= '0;
      valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      mem_read_q <= mem_read_d;
      mem_write_q <= mem_write_d;
      wb_en_q <= wb_en_d;
      br_q <= br_d;
      exe_cmd_q <= exe_cmd_d;
      val1_q <= val1_d;
      val2_q <= val2_d;
      st_val_q <= st_val_d;
      dest_q <= dest_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef FORWARDING_EN
  logic [REG_W-1:0] src1_d, src1_q, src2_d, src2_q;
  always_comb begin
    src1_d = freeze ? src1_q : bub ? '0 : src1_in;
    src2_d = freeze ? src2_q : bub ? '0 : src2_in;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      src1_q <= '0;
      src2_q <= '0;
    end else begin
      src1_q <= src1_d;
      src2_q <= src2_d;
    end
  end
  assign src1_out = src1_q;
  assign src2_out = src2_q;
`else
  logic unused_src;
  assign unused_src = ^{src1_in, src2_in};
  assign src1_out = '0;
  assign src2_out = '0;
`endif
  assign pc_out = pc_q;
  assign mem_read_out = mem_read_q;
  assign mem_write_out = mem_write_q;
  assign wb_en_out = wb_en_q;
  assign br_out = br_q;
  assign exe_cmd_out = exe_cmd_q;
  assign val1_out = val1_q;
  assign val2_out = val2_q;
  assign st_val_out = st_val_q;
  assign dest_out = dest_q;
  assign valid_out = valid_q;
  assign bubble_cnt = cnt_q;
endmodule
